timer_bus_master: RTL
=====================

TIMER_BUS_MASTER -- requirements
Module: timer_bus_master

Interface
REQ-001 Parameter P_GNT_TIMEOUT, default 16, SHALL set the maximum number of cycles req is held high without gnt before the transaction aborts.
REQ-002 Parameter P_ERR_CNT_W, default 8, SHALL set the width of err_cnt.
REQ-003 clk  in  1  single clock; all logic on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  master can accept a command.
REQ-007 cmd_write  in  1  1 = write, 0 = read.
REQ-008 cmd_addr  in  P_ADDR_WIDTH  target register address.
REQ-009 cmd_wdata  in  P_DATA_WIDTH  write data.
REQ-010 req  out  1  bus request to the timer peripheral.
REQ-011 gnt  in  1  one-cycle grant pulse from the timer peripheral.
REQ-012 addr / wdata / write_en  out  P_ADDR_WIDTH / P_DATA_WIDTH / 1  bus address, data and direction.
REQ-013 rdata  in  P_DATA_WIDTH  read data, valid only in the gnt=1 cycle.
REQ-014 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-015 rsp_rdata  out  P_DATA_WIDTH  captured read data; 0 for writes and errors.
REQ-016 rsp_err  out  1  transaction aborted on timeout.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 err_cnt  out  P_ERR_CNT_W  saturating count of timeouts.

Function
REQ-019 FSM states SHALL be IDLE, REQ and RESP.
REQ-020 IDLE: cmd_ready=1; on cmd_valid, capture cmd_* into addr/wdata/write_en and go to REQ; req rises on the cycle after the accept edge.
REQ-021 REQ: req=1; addr, wdata and write_en SHALL stay stable until gnt is sampled; cmd_ready=0.
REQ-022 REQ, gnt=1: capture rdata (reads) or 0 (writes) into rsp_rdata; set rsp_err=0; deassert req on the same edge; go to RESP.
REQ-023 REQ timeout counter: cleared on entry, incremented each cycle gnt=0.
REQ-024 Timeout abort: when the counter reaches P_GNT_TIMEOUT-1 with gnt=0, drop req; set rsp_err=1 and rsp_rdata=0; increment err_cnt, saturating at all-ones; go to RESP.
REQ-025 If gnt=1 arrives on the same cycle the timeout would fire, gnt SHALL win: normal completion, no error.
REQ-026 RESP: rsp_valid=1 with rsp_* held stable; on rsp_ready go to IDLE.
REQ-027 Back-to-back commands SHALL have req low for at least 2 cycles between them (RESP and IDLE), which guarantees the peripheral sees the abort or idle.
REQ-028 A gnt received outside REQ SHALL be ignored.
REQ-029 Accept-to-rsp_valid latency SHALL be 2 + (cycles from req rising to gnt visible).

Reset
REQ-030 While reset=1, on the clock edge: FSM goes to IDLE; req, rsp_valid and rsp_err go to 0; addr, wdata, write_en and rsp_rdata go to 0; timeout counter and err_cnt go to 0; busy=0; cmd_ready=1 in the first cycle after reset is released.
REQ-031 Reset asserted mid-REQ SHALL drop req on that edge; any in-flight transaction is discarded with no response.

Structure
REQ-032 The following SHALL come from design_params_pkg: P_ADDR_WIDTH, P_DATA_WIDTH, P_ADDR_CONTROL/LOAD/STATUS, and the P_BIT_* constants.
REQ-033 The state enum bm_state_e and the P_GNT_TIMEOUT default SHALL be added to design_params_pkg.
REQ-034 There SHALL be a single module with no sub-modules.

Verification
REQ-035 Write LOAD=0x0005, then CONTROL=0x1 (START): two write responses with rsp_err=0; the peripheral counts down and sets expired after 6 cycles.
REQ-036 Read STATUS after expiry: rsp_rdata=0x1; a second read of STATUS returns 0x0 (read-clear).
REQ-037 gnt tied low: req held exactly 16 cycles, then rsp_err=1, rsp_rdata=0, err_cnt=1; 256 such aborts leave err_cnt=255.
REQ-038 rsp_ready held low 5 cycles after rsp_valid: rsp_* stable, cmd_ready=0, no new req.
REQ-039 gnt on the 16th req cycle: rsp_err=0 and err_cnt unchanged.
REQ-040 reset pulse during REQ: req=0 on the next cycle, no rsp_valid, and the next command completes normally.

Source files
------------

// File: rtl/design_params_pkg.sv
// Shared parameters, register map and state type for the timer bus master.
// Imported by the timer_bus_master RTL and its bench.
package design_params_pkg;

  localparam int P_ADDR_WIDTH = 8;
  localparam int P_DATA_WIDTH = 16;

  localparam logic [P_ADDR_WIDTH-1:0] P_ADDR_CONTROL = 8'h00;
  localparam logic [P_ADDR_WIDTH-1:0] P_ADDR_LOAD    = 8'h04;
  localparam logic [P_ADDR_WIDTH-1:0] P_ADDR_STATUS  = 8'h08;

  localparam int P_BIT_START   = 0;
  localparam int P_BIT_IRQ_EN  = 1;
  localparam int P_BIT_EXPIRED = 0;

  localparam int P_GNT_TIMEOUT_DFLT = 16;

  typedef enum logic [1:0] {
    BM_IDLE = 2'd0,
    BM_REQ  = 2'd1,
    BM_RESP = 2'd2
  } bm_state_e;

endpackage

// File: rtl/timer_bus_master.sv
// Single-outstanding bus master for the timer peripheral with
// grant timeout, abort reporting and a saturating error counter.
module timer_bus_master
  import design_params_pkg::*;
#(
  parameter int P_GNT_TIMEOUT = P_GNT_TIMEOUT_DFLT,
  parameter int P_ERR_CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [P_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [P_DATA_WIDTH-1:0] cmd_wdata,
  output logic                    req,
  input  logic                    gnt,
  output logic [P_ADDR_WIDTH-1:0] addr,
  output logic [P_DATA_WIDTH-1:0] wdata,
  output logic                    write_en,
  input  logic [P_DATA_WIDTH-1:0] rdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [P_DATA_WIDTH-1:0] rsp_rdata,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [P_ERR_CNT_W-1:0]  err_cnt
);

  localparam int TW =
    (P_GNT_TIMEOUT > 1) ? $clog2(P_GNT_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(P_GNT_TIMEOUT - 1);

  bm_state_e     state;
  bm_state_e     state_n;
  logic [TW-1:0] tcnt;
  logic          accept;
  logic          done_ok;
  logic          done_to;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BM_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // gnt wins over a timeout that would fire in the same cycle
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    done_ok = 1'b0;
    done_to = 1'b0;
    unique case (state)
      BM_IDLE: begin
        if (cmd_valid) begin
          state_n = BM_REQ;
          accept  = 1'b1;
        end
      end
      BM_REQ: begin
        if (gnt) begin
          state_n = BM_RESP;
          done_ok = 1'b1;
        end else if (tcnt == T_LAST) begin
          state_n = BM_RESP;
          done_to = 1'b1;
        end
      end
      BM_RESP: begin
        if (rsp_ready) begin
          state_n = BM_IDLE;
        end
      end
      default: begin
        state_n = BM_IDLE;
      end
    endcase
  end

  assign cmd_ready = (state == BM_IDLE);
  assign busy      = (state != BM_IDLE);
  assign rsp_valid = (state == BM_RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      req      <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      write_en <= 1'b0;
      tcnt     <= '0;
    end else begin
      req <= (state_n == BM_REQ);
      if (accept) begin
        addr     <= cmd_addr;
        wdata    <= cmd_wdata;
        write_en <= cmd_write;
        tcnt     <= '0;
      end else if (state == BM_REQ && !gnt && !done_to) begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (done_ok) begin
        rsp_rdata <= write_en ? '0 : rdata;
        rsp_err   <= 1'b0;
      end
      if (done_to) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
        if (err_cnt != '1) begin
          err_cnt <= err_cnt + 1'b1;
        end
      end
    end
  end

endmodule
